// File: rtl/loadbyte_unit.sv
// Multicycle load-byte engine. It reads one 16-bit word from data memory
// through a req/ready handshake. It then selects the addressed byte and
// zero- or sign-extends that byte to 16 bits for register write-back.
// A bounded wait counter aborts a read that the memory never acknowledges.
module loadbyte_unit #(
  parameter int TIMEOUT = 15  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic        signed_ld,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // The last REQ cycle that may pass without a ready.
  // The counter therefore never needs to reach TIMEOUT and cannot wrap.
  localparam logic [7:0] last_wait = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  wait_cnt;
  logic        addr_lsb;
  logic        sign_mode;
  logic [7:0]  sel_byte;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) assignments.
  // Every flop then samples its pre-edge value, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. A ready in REQ takes priority over the timeout check.
  // NOTE: the default assignment to state_nx comes first.
  // Every path through the case then assigns it, so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = REQ;
      REQ: begin
        if (mem_ready)                  state_nx = DONE;
        else if (wait_cnt == last_wait) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte lane selection from the latched address bit.
  // The store path places an even-address byte in bits [7:0].
  always_comb begin
    sel_byte = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
  end

  // Datapath:
  //  - latch the request when start is taken;
  //  - count wait states;
  //  - capture the extended byte on ready.
  // rdata is deliberately left alone on a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 16'h0000;
      addr_lsb  <= 1'b0;
      sign_mode <= 1'b0;
      wait_cnt  <= 8'h00;
      rdata     <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= {addr[15:1], 1'b0};
            addr_lsb  <= addr[0];
            sign_mode <= signed_ld;
            wait_cnt  <= 8'h00;
          end
        end
        REQ: begin
          if (mem_ready)
            rdata <= {{8{sign_mode & sel_byte[7]}}, sel_byte};
          else if (wait_cnt != last_wait)
            wait_cnt <= wait_cnt + 8'h01;
        end
        default: ;
      endcase
    end
  end

  // Control outputs decode the state register only.
  // No input reaches an output combinationally.
  assign mem_req = (state == REQ);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign err     = (state == ERR);

endmodule
